// File: rtl/uart_frame_rx_ctrl.sv
// Frame controller behind a UART receiver: parses SOF|LEN|PAYLOAD|CSUM frames,
// buffers and verifies them, then releases the payload on a valid/ready byte stream.
module uart_frame_rx_ctrl #(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int          TIMEOUT_CLKS = 3480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_recv,
  input  logic        recv_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err_len,
  output logic        err_csum,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic [15:0] frame_count
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          err_len_q, err_len_d;
  logic          err_csum_q, err_csum_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;
  logic          wr_en;
  logic [7:0]    rd_data_q;
  logic          last_beat;

  logic [7:0] buf_mem [0:MAX_LEN-1];

  assign last_beat = (rd_idx_q == len_q - 8'd1);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    csum_d        = csum_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    timer_d       = timer_q;
    frame_count_d = frame_count_q;
    err_len_d     = 1'b0;
    err_csum_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    wr_en         = 1'b0;

    // Shared inter-byte watchdog for the in-frame states; a byte in the expiry cycle wins.
    if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CSUM) begin
      if (recv_valid) begin
        timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
        timer_d       = '0;
        err_timeout_d = 1'b1;
        state_d       = ST_IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (recv_valid && byte_recv == SOF) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (recv_valid) begin
          if (byte_recv == 8'd0 || byte_recv > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d    = byte_recv;
            csum_d   = byte_recv;
            wr_idx_d = 8'd0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (recv_valid) begin
          wr_en    = 1'b1;
          csum_d   = csum_q ^ byte_recv;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == len_q - 8'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (recv_valid) begin
          if (byte_recv == csum_q) begin
            rd_idx_d = 8'd0;
            state_d  = ST_DRAIN;
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (recv_valid) err_overrun_d = 1'b1;
        if (out_ready) begin
          if (last_beat) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= 8'd0;
      csum_q        <= 8'd0;
      wr_idx_q      <= 8'd0;
      rd_idx_q      <= 8'd0;
      timer_q       <= '0;
      frame_count_q <= 16'd0;
      err_len_q     <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      csum_q        <= csum_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      timer_q       <= timer_d;
      frame_count_q <= frame_count_d;
      err_len_q     <= err_len_d;
      err_csum_q    <= err_csum_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Read address follows rd_idx_d so the registered read lines up with rd_idx_q.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_idx_q[AW-1:0]] <= byte_recv;
    rd_data_q <= buf_mem[rd_idx_d[AW-1:0]];
  end

  assign out_valid   = (state_q == ST_DRAIN);
  assign out_data    = out_valid ? rd_data_q : 8'h00;
  assign out_last    = out_valid & last_beat;
  assign busy        = (state_q != ST_IDLE);
  assign err_len     = err_len_q;
  assign err_csum    = err_csum_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Directed self-checking bench for uart_frame_rx_ctrl (default parameters).
module tb_uart_frame_rx_ctrl;

  localparam int TO = 3480;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_recv;
  logic        recv_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        err_len;
  logic        err_csum;
  logic        err_timeout;
  logic        err_overrun;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  int n_err_len = 0, n_err_csum = 0, n_err_timeout = 0, n_err_overrun = 0, n_valid = 0;
  logic [7:0] got_data[$];
  logic       got_last[$];

  uart_frame_rx_ctrl dut (
    .clk(clk), .rst(rst), .byte_recv(byte_recv), .recv_valid(recv_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err_len(err_len), .err_csum(err_csum), .err_timeout(err_timeout),
    .err_overrun(err_overrun), .frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (err_len) n_err_len++;
    if (err_csum) n_err_csum++;
    if (err_timeout) n_err_timeout++;
    if (err_overrun) n_err_overrun++;
    if (out_valid) n_valid++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; strobes one byte for exactly one cycle.
  task automatic send(input logic [7:0] b);
    byte_recv  = b;
    recv_valid = 1'b1;
    @(negedge clk);
    recv_valid = 1'b0;
    byte_recv  = 8'h00;
  endtask

  // mode 0: ready always high; mode 1: ready alternates starting low.
  task automatic collect(input int mode, input int max_cyc);
    bit done = 0;
    got_data.delete();
    got_last.delete();
    for (int c = 0; c < max_cyc && !done; c++) begin
      out_ready = (mode == 0) ? 1'b1 : c[0];
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last) done = 1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pack_data();
    logic [31:0] v = '0;
    for (int i = 0; i < got_data.size() && i < 4; i++) v = {v[23:0], got_data[i]};
    return v;
  endfunction

  function automatic logic [3:0] pack_last();
    logic [3:0] v = '0;
    for (int i = 0; i < got_last.size() && i < 4; i++) v = {v[2:0], got_last[i]};
    return v;
  endfunction

  task automatic test_reset();
    checks++;
    if ({busy, out_valid, out_last, err_len, err_csum, err_timeout, err_overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, out_valid, out_last, err_len, err_csum, err_timeout, err_overrun});
    end
    checks++;
    if ({out_data, frame_count} !== 24'h0) begin
      errors++;
      $display("FAIL reset_values: out_data=%h frame_count=%0d expected 0/0", out_data, frame_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    int e0 = n_err_len + n_err_csum + n_err_timeout + n_err_overrun;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL good_latency: valid/data=%b/%h expected 1/11", out_valid, out_data);
    end
    collect(0, 20);
    checks++;
    if (got_data.size() !== 3 || pack_data() !== 32'h00112233 || pack_last() !== 4'b0001) begin
      errors++;
      $display("FAIL good_data: n=%0d data=%h last=%b expected 3/00112233/0001",
               got_data.size(), pack_data(), pack_last());
    end
    checks++;
    if ({out_valid, frame_count} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL good_count: valid=%b frame_count=%0d expected 0/1", out_valid, frame_count);
    end
    checks++;
    if (n_err_len + n_err_csum + n_err_timeout + n_err_overrun !== e0) begin
      errors++;
      $display("FAIL good_noerr: error pulses=%0d expected 0",
               n_err_len + n_err_csum + n_err_timeout + n_err_overrun - e0);
    end
  endtask

  task automatic test_bad_csum();
    int v0 = n_valid;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    checks++;
    if ({err_csum, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL csum_pulse: err_csum/out_valid=%b expected 10", {err_csum, out_valid});
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({err_csum, busy, n_valid - v0} !== {2'b00, 32'd0}) begin
      errors++;
      $display("FAIL csum_after: err_csum=%b busy=%b valid_cycles=%0d expected 0/0/0",
               err_csum, busy, n_valid - v0);
    end
  endtask

  task automatic test_length();
    send(8'hA5); send(8'h00);
    checks++;
    if ({err_len, busy} !== 2'b10) begin
      errors++;
      $display("FAIL len_zero: err_len/busy=%b expected 10", {err_len, busy});
    end
    send(8'hA5); send(8'h11);
    checks++;
    if ({err_len, busy} !== 2'b10) begin
      errors++;
      $display("FAIL len_big: err_len/busy=%b expected 10", {err_len, busy});
    end
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    collect(0, 10);
    checks++;
    if (got_data.size() !== 1 || pack_data() !== 32'h7E || pack_last() !== 4'b0001 ||
        frame_count !== 16'd2) begin
      errors++;
      $display("FAIL len_recover: n=%0d data=%h last=%b count=%0d expected 1/7e/0001/2",
               got_data.size(), pack_data(), pack_last(), frame_count);
    end
  endtask

  task automatic test_timeout();
    send(8'hA5); send(8'h02); send(8'h11);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if ({err_timeout, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early: err_timeout/busy=%b expected 01", {err_timeout, busy});
    end
    @(negedge clk);
    checks++;
    if ({err_timeout, busy} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_pulse: err_timeout/busy=%b expected 10", {err_timeout, busy});
    end
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: err_timeout=%b expected 0", err_timeout);
    end
    send(8'hA5); send(8'h02); send(8'h11);
    repeat (TO - 1) @(negedge clk);
    send(8'h22);
    checks++;
    if ({err_timeout, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_edge_byte: err_timeout/busy=%b expected 01", {err_timeout, busy});
    end
    send(8'h31);
    collect(0, 10);
    checks++;
    if (got_data.size() !== 2 || pack_data() !== 32'h1122 || pack_last() !== 4'b0001 ||
        frame_count !== 16'd3) begin
      errors++;
      $display("FAIL timeout_edge_frame: n=%0d data=%h last=%b count=%0d expected 2/1122/0001/3",
               got_data.size(), pack_data(), pack_last(), frame_count);
    end
  endtask

  task automatic test_backpressure();
    int e0 = n_err_len + n_err_csum + n_err_timeout + n_err_overrun;
    out_ready = 1'b0;
    send(8'h00); send(8'hFF);
    checks++;
    if ({busy, 32'(n_err_len + n_err_csum + n_err_timeout + n_err_overrun - e0)} !== 33'd0) begin
      errors++;
      $display("FAIL garbage_ignored: busy=%b new_errors=%0d expected 0/0", busy,
               n_err_len + n_err_csum + n_err_timeout + n_err_overrun - e0);
    end
    send(8'hA5); send(8'h04); send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h44);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, out_data, out_last} !== {1'b1, 8'h10, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid/data/last=%b/%h/%b expected 1/10/0",
                 c, out_valid, out_data, out_last);
      end
      if (c == 1) begin
        byte_recv  = 8'h55;
        recv_valid = 1'b1;
      end
      if (c == 2) begin
        recv_valid = 1'b0;
        byte_recv  = 8'h00;
        checks++;
        if (err_overrun !== 1'b1) begin
          errors++;
          $display("FAIL overrun_pulse: err_overrun=%b expected 1", err_overrun);
        end
      end
      if (c == 3) begin
        checks++;
        if (err_overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_width: err_overrun=%b expected 0", err_overrun);
        end
      end
      @(negedge clk);
    end
    collect(1, 40);
    checks++;
    if (got_data.size() !== 4 || pack_data() !== 32'h10203040 || pack_last() !== 4'b0001 ||
        frame_count !== 16'd4) begin
      errors++;
      $display("FAIL backpressure_data: n=%0d data=%h last=%b count=%0d expected 4/10203040/0001/4",
               got_data.size(), pack_data(), pack_last(), frame_count);
    end
  endtask

  task automatic test_reset_abort();
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, out_data, frame_count} !== 26'd0) begin
      errors++;
      $display("FAIL rst_payload: busy=%b valid=%b data=%h count=%0d expected all 0",
               busy, out_valid, out_data, frame_count);
    end
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_drain_setup: out_valid=%b expected 1", out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, out_last, out_data, frame_count} !== 27'd0) begin
      errors++;
      $display("FAIL rst_drain: busy=%b valid=%b last=%b data=%h count=%0d expected all 0",
               busy, out_valid, out_last, out_data, frame_count);
    end
    rst = 1'b0;
    @(negedge clk);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    collect(0, 20);
    checks++;
    if (got_data.size() !== 3 || pack_data() !== 32'h00112233 || pack_last() !== 4'b0001 ||
        frame_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_recover: n=%0d data=%h last=%b count=%0d expected 3/00112233/0001/1",
               got_data.size(), pack_data(), pack_last(), frame_count);
    end
  endtask

  initial begin
    rst        = 1'b1;
    byte_recv  = 8'h00;
    recv_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    test_good_frame();
    $display("test_good_frame done: checks=%0d errors=%0d", checks, errors);
    test_bad_csum();
    $display("test_bad_csum done: checks=%0d errors=%0d", checks, errors);
    test_length();
    $display("test_length done: checks=%0d errors=%0d", checks, errors);
    test_timeout();
    $display("test_timeout done: checks=%0d errors=%0d", checks, errors);
    test_backpressure();
    $display("test_backpressure done: checks=%0d errors=%0d", checks, errors);
    test_reset_abort();
    $display("test_reset_abort done: checks=%0d errors=%0d", checks, errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
